// File: rtl/dtc_pkg.sv
// Shared types and constants for the decision-tree classifier vote stage.
package dtc_pkg;

  // Width of a class code and the number of classes it can name.
  localparam int CLASS_W   = 3;
  localparam int N_CLASSES = 1 << CLASS_W;

  typedef logic [CLASS_W-1:0] class_t;

  // ACCUM: collect a window, SCAN: walk the histogram, HOLD: present the decision.
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/dtc_class_hist.sv
// Per-class vote counter bank: one increment port, one synchronous clear,
// and a registered read port used by the majority scan.
module dtc_class_hist
  import dtc_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  class_t           inc_idx,
  input  logic             clr,
  input  class_t           rd_idx,
  output logic [CNT_W-1:0] rd_count
);

  logic [CNT_W-1:0] cnt [N_CLASSES];

  // Vote counters: clear wins over increment; the two never coincide in practice.
  // NOTE: the bank is a handful of flops, so it takes the async reset directly;
  // a RAM-based histogram could not be reset this way and would rely on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
    end else if (inc_en) begin
      // NOTE: non-blocking so every reader in this edge sees the pre-increment value.
      cnt[inc_idx] <= cnt[inc_idx] + CNT_W'(1);
    end
  end

  // Registered read: the scan sees cnt[rd_idx] one cycle after presenting the index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_count <= '0;
    else     rd_count <= cnt[rd_idx];
  end

endmodule

// File: rtl/dtc_vote_accum.sv
// Windowed majority vote over classifier predictions: accumulate WIN samples,
// scan the histogram one class per cycle, then hold the decision until taken.
module dtc_vote_accum
  import dtc_pkg::*;
#(
  parameter int WIN   = 16,
  parameter int CNT_W = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  class_t           in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output class_t           out_class,
  output logic [CNT_W-1:0] out_count,
  output logic             out_tie
);

  // Scan counter runs 0..N_CLASSES: issue reads at 0..N-1, compare at 1..N.
  localparam int                SCAN_W    = CLASS_W + 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(N_CLASSES);
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WIN - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  samples;
  logic [SCAN_W-1:0] scan_cnt;
  logic [SCAN_W-1:0] scan_prev;
  class_t            rd_idx, cmp_idx;
  logic [CNT_W-1:0]  rd_count;
  class_t            best_class, best_class_next;
  logic [CNT_W-1:0]  best_cnt, best_cnt_next;
  logic              best_tie, best_tie_next;
  logic              accept, scan_done, handshake;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign scan_done = (state == SCAN) && (scan_cnt == SCAN_LAST);
  assign scan_prev = scan_cnt - SCAN_W'(1);
  assign rd_idx    = scan_cnt[CLASS_W-1:0];
  assign cmp_idx   = scan_prev[CLASS_W-1:0];

  dtc_class_hist #(
    .CNT_W (CNT_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (accept),
    .inc_idx  (in_class),
    .clr      (handshake),
    .rd_idx   (rd_idx),
    .rd_count (rd_count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = ~rst;
        if (in_valid && !rst && (samples == WIN_LAST)) state_next = SCAN;
      end
      SCAN: begin
        if (scan_done) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // Sample counter: wraps to zero on the WIN-th accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples <= '0;
    end else if (accept) begin
      samples <= (samples == WIN_LAST) ? '0 : samples + CNT_W'(1);
    end
  end

  // Running best for the class whose count just came out of the read port.
  always_comb begin
    best_class_next = best_class;
    best_cnt_next   = best_cnt;
    best_tie_next   = best_tie;
    if (cmp_idx == '0) begin
      best_class_next = '0;
      best_cnt_next   = rd_count;
      best_tie_next   = 1'b0;
    end else if (rd_count > best_cnt) begin
      // Strict compare keeps the lowest index on equal counts.
      best_class_next = cmp_idx;
      best_cnt_next   = rd_count;
      best_tie_next   = 1'b0;
    end else if (rd_count == best_cnt) begin
      best_tie_next   = 1'b1;
    end
  end

  // Scan index and running-best registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt   <= '0;
      best_class <= '0;
      best_cnt   <= '0;
      best_tie   <= 1'b0;
    end else if (state == SCAN) begin
      scan_cnt <= scan_done ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_cnt != '0) begin
        best_class <= best_class_next;
        best_cnt   <= best_cnt_next;
        best_tie   <= best_tie_next;
      end
    end else begin
      scan_cnt <= '0;
    end
  end

  // Decision registers: load at the end of the scan, clear once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_class <= '0;
      out_count <= '0;
      out_tie   <= 1'b0;
    end else if (scan_done) begin
      out_class <= best_class_next;
      out_count <= best_cnt_next;
      out_tie   <= best_tie_next;
    end else if (handshake) begin
      out_class <= '0;
      out_count <= '0;
      out_tie   <= 1'b0;
    end
  end

endmodule
